// File: rtl/vec_rf_pkg.sv
// Shared constants and stream FSM encoding for the streaming vector register file.
package vec_rf_pkg;

  localparam int unsigned NUM_READ_PORTS_DEF = 2;
  localparam int unsigned REG_BITS_DEF       = 5;
  localparam int unsigned VLEN_ELEMS_DEF     = 8;
  localparam int unsigned DATA_LENGTH_DEF    = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } stream_state_e;

  // Element index width; never zero so a single-element register still has a select bit.
  function automatic int unsigned elem_idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_rf_read_port.sv
// One element-streaming read port: launch, RAW chaining against the active write, and
// a single output register stage with valid/ready handshake.
module vec_rf_read_port
  import vec_rf_pkg::*;
#(
  parameter int unsigned REG_BITS    = REG_BITS_DEF,
  parameter int unsigned VLEN_ELEMS  = VLEN_ELEMS_DEF,
  parameter int unsigned DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int unsigned VL_BITS     = $clog2(VLEN_ELEMS + 1)
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_i,
  input  logic [2**REG_BITS-1:0][VLEN_ELEMS-1:0][DATA_LENGTH-1:0] i_mem,
  input  logic                                                 i_start,
  input  logic [REG_BITS-1:0]                                  i_reg,
  input  logic [VL_BITS-1:0]                                   i_vl,
  input  logic                                                 i_ready,
  input  logic                                                 i_wr_busy,
  input  logic [REG_BITS-1:0]                                  i_wr_reg,
  input  logic [VL_BITS-1:0]                                   i_wr_cnt,
  output logic                                                 o_valid,
  output logic [DATA_LENGTH-1:0]                               o_data,
  output logic                                                 o_last,
  output logic                                                 o_busy
);

  localparam int unsigned        EIDX_W = elem_idx_width(VLEN_ELEMS);
  localparam logic [VL_BITS-1:0] VL_MAX = VL_BITS'(VLEN_ELEMS);
  localparam logic [VL_BITS-1:0] VL_ONE = VL_BITS'(1);

  stream_state_e          r_state;
  logic [REG_BITS-1:0]    r_reg;
  logic [VL_BITS-1:0]     r_vl;
  logic [VL_BITS-1:0]     r_cnt;
  logic                   r_valid;
  logic                   r_last;
  logic [DATA_LENGTH-1:0] r_data;

  logic                   w_launch;
  logic                   w_hazard;
  logic                   w_consume;
  logic                   w_fetch;
  logic [VL_BITS-1:0]     w_vl_clamped;
  logic [DATA_LENGTH-1:0] w_elem;

  assign w_vl_clamped = (i_vl > VL_MAX) ? VL_MAX : i_vl;
  assign w_launch     = (r_state == ST_IDLE) && i_start && (i_vl != '0);
  // Element k of the register being written is only fetchable once the writer has moved past it.
  assign w_hazard     = i_wr_busy && (i_wr_reg == r_reg) && (r_cnt >= i_wr_cnt);
  assign w_consume    = r_valid && i_ready;
  assign w_fetch      = (r_state == ST_ACTIVE) && (r_cnt < r_vl) &&
                        (!r_valid || i_ready) && !w_hazard;
  assign w_elem       = i_mem[r_reg][r_cnt[EIDX_W-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_reg   <= '0;
      r_vl    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state <= ST_ACTIVE;
            r_reg   <= i_reg;
            r_vl    <= w_vl_clamped;
            r_cnt   <= '0;
          end
        end
        ST_ACTIVE: begin
          if (w_fetch) begin
            r_data  <= w_elem;
            r_valid <= 1'b1;
            r_last  <= (r_cnt == r_vl - VL_ONE);
            r_cnt   <= r_cnt + VL_ONE;
          end else if (w_consume) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
          if (w_consume && r_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_busy  = (r_state == ST_ACTIVE);

endmodule

// File: rtl/vec_regfile_stream.sv
// Flop-based vector register file with one streaming write port and NUM_READ_PORTS
// streaming read ports that chain element-by-element behind an in-flight write.
module vec_regfile_stream
  import vec_rf_pkg::*;
#(
  parameter int unsigned NUM_READ_PORTS = NUM_READ_PORTS_DEF,
  parameter int unsigned REG_BITS       = REG_BITS_DEF,
  parameter int unsigned VLEN_ELEMS     = VLEN_ELEMS_DEF,
  parameter int unsigned DATA_LENGTH    = DATA_LENGTH_DEF,
  parameter int unsigned VL_BITS        = $clog2(VLEN_ELEMS + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wr_start_i,
  input  logic [REG_BITS-1:0]                 wr_reg_i,
  input  logic [VL_BITS-1:0]                  wr_vl_i,
  input  logic                                wr_valid_i,
  input  logic [DATA_LENGTH-1:0]              wr_data_i,
  output logic                                wr_ready_o,
  output logic                                wr_busy_o,
  input  logic [NUM_READ_PORTS-1:0]           rd_start_i,
  input  logic [NUM_READ_PORTS*REG_BITS-1:0]  rd_reg_i,
  input  logic [NUM_READ_PORTS*VL_BITS-1:0]   rd_vl_i,
  output logic [NUM_READ_PORTS-1:0]           rd_valid_o,
  output logic [NUM_READ_PORTS*DATA_LENGTH-1:0] rd_data_o,
  output logic [NUM_READ_PORTS-1:0]           rd_last_o,
  input  logic [NUM_READ_PORTS-1:0]           rd_ready_i,
  output logic [NUM_READ_PORTS-1:0]           rd_busy_o
);

  localparam int unsigned        NUM_REGS = 2**REG_BITS;
  localparam int unsigned        EIDX_W   = elem_idx_width(VLEN_ELEMS);
  localparam logic [VL_BITS-1:0] VL_MAX   = VL_BITS'(VLEN_ELEMS);
  localparam logic [VL_BITS-1:0] VL_ONE   = VL_BITS'(1);

  logic [NUM_REGS-1:0][VLEN_ELEMS-1:0][DATA_LENGTH-1:0] r_mem;

  stream_state_e       r_wr_state;
  logic [REG_BITS-1:0] r_wr_reg;
  logic [VL_BITS-1:0]  r_wr_vl;
  logic [VL_BITS-1:0]  r_wr_cnt;

  logic                w_wr_launch;
  logic                w_wr_accept;
  logic                w_wr_last;
  logic [VL_BITS-1:0]  w_wr_vl_clamped;

  assign w_wr_vl_clamped = (wr_vl_i > VL_MAX) ? VL_MAX : wr_vl_i;
  assign w_wr_launch     = (r_wr_state == ST_IDLE) && wr_start_i && (wr_vl_i != '0);
  assign w_wr_accept     = (r_wr_state == ST_ACTIVE) && wr_valid_i;
  assign w_wr_last       = (r_wr_cnt == r_wr_vl - VL_ONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_state <= ST_IDLE;
      r_wr_reg   <= '0;
      r_wr_vl    <= '0;
      r_wr_cnt   <= '0;
    end else begin
      case (r_wr_state)
        ST_IDLE: begin
          if (w_wr_launch) begin
            r_wr_state <= ST_ACTIVE;
            r_wr_reg   <= wr_reg_i;
            r_wr_vl    <= w_wr_vl_clamped;
            r_wr_cnt   <= '0;
          end
        end
        ST_ACTIVE: begin
          if (w_wr_accept) begin
            if (w_wr_last) begin
              r_wr_state <= ST_IDLE;
              r_wr_cnt   <= '0;
            end else begin
              r_wr_cnt   <= r_wr_cnt + VL_ONE;
            end
          end
        end
      endcase
    end
  end

  // Storage is deliberately not reset: an aborted write leaves already-written elements intact.
  always_ff @(posedge clk_i) begin
    if (w_wr_accept) begin
      r_mem[r_wr_reg][r_wr_cnt[EIDX_W-1:0]] <= wr_data_i;
    end
  end

  assign wr_ready_o = (r_wr_state == ST_ACTIVE);
  assign wr_busy_o  = (r_wr_state == ST_ACTIVE);

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    vec_rf_read_port #(
      .REG_BITS    (REG_BITS),
      .VLEN_ELEMS  (VLEN_ELEMS),
      .DATA_LENGTH (DATA_LENGTH),
      .VL_BITS     (VL_BITS)
    ) u_rd (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_mem    (r_mem),
      .i_start  (rd_start_i[p]),
      .i_reg    (rd_reg_i[p*REG_BITS +: REG_BITS]),
      .i_vl     (rd_vl_i[p*VL_BITS +: VL_BITS]),
      .i_ready  (rd_ready_i[p]),
      .i_wr_busy(wr_busy_o),
      .i_wr_reg (r_wr_reg),
      .i_wr_cnt (r_wr_cnt),
      .o_valid  (rd_valid_o[p]),
      .o_data   (rd_data_o[p*DATA_LENGTH +: DATA_LENGTH]),
      .o_last   (rd_last_o[p]),
      .o_busy   (rd_busy_o[p])
    );
  end

endmodule

// File: doc/vec_regfile_stream.md
Name: vec_regfile_stream

Overview:
- Vector register file: 2**REG_BITS vector registers × VLEN_ELEMS elements × DATA_LENGTH bits, all in flops.
- One element-streaming write port and NUM_READ_PORTS element-streaming read ports.
- Each stream is launched with a register index and a vector length. Elements then move one per cycle per port under valid/ready.
- Read-after-write chaining: a read of the register currently being written stalls per element until that element is written. Sits between the vector issue logic and the vector lanes.

Parameters:
- NUM_READ_PORTS, 2, number of independent read streams.
- REG_BITS, 5, register index width (32 registers).
- VLEN_ELEMS, 8, elements per register (max vector length).
- DATA_LENGTH, 8, element width in bits.
- VL_BITS, $clog2(VLEN_ELEMS+1), vector-length field width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- wr_start_i  in  1  launch write stream.
- wr_reg_i  in  REG_BITS  destination register.
- wr_vl_i  in  VL_BITS  write vector length.
- wr_valid_i  in  1  element valid.
- wr_data_i  in  DATA_LENGTH  element data.
- wr_ready_o  out  1  write element accepted when valid&ready.
- wr_busy_o  out  1  write stream active.
- rd_start_i  in  NUM_READ_PORTS  per-port launch.
- rd_reg_i  in  NUM_READ_PORTS*REG_BITS  per-port source register (port p at [p*REG_BITS +: REG_BITS]).
- rd_vl_i  in  NUM_READ_PORTS*VL_BITS  per-port vector length.
- rd_valid_o  out  NUM_READ_PORTS  output element valid.
- rd_data_o  out  NUM_READ_PORTS*DATA_LENGTH  output element.
- rd_last_o  out  NUM_READ_PORTS  qualifies the final element of the stream.
- rd_ready_i  in  NUM_READ_PORTS  consumer ready.
- rd_busy_o  out  NUM_READ_PORTS  read stream active.

Behaviour:
- Reset, asynchronous: all busy=0, wr_ready_o=0, rd_valid_o=0, rd_last_o=0, rd_data_o=0, all counters=0. Register contents are not reset (X until written).
- Vector length: vl is sampled at start. vl=0 means the start is ignored. vl>VLEN_ELEMS is clamped to VLEN_ELEMS.
- Start when busy: ignored, no effect on the running stream.
- Write FSM, IDLE/ACTIVE:
  - wr_ready_o = ACTIVE.
  - Each valid&ready writes element wr_cnt and increments wr_cnt.
  - On the element with wr_cnt==vl-1: return to IDLE, wr_cnt=0.
  - First element is accepted the cycle after start.
- Read FSM per port, IDLE/ACTIVE:
  - Fetch counter rd_cnt. Output register stage holds data/valid/last.
  - Fetch happens when ACTIVE, rd_cnt<vl, (!rd_valid_o || rd_ready_i), and no hazard.
  - Fetch loads the output register the same edge, so latency is start→first rd_valid_o = 2 cycles when there is no hazard.
  - Full throughput is one element per cycle with ready held high.
  - The port returns to IDLE when the last element is consumed (valid&ready&last). A new start is accepted the following cycle.
- Hazard (RAW chaining):
  - Condition: wr_busy_o && wr_reg==rd_reg && rd_cnt>=wr_cnt → fetch stalls, rd_valid_o drops after the current element is consumed.
  - A write of element k at edge t makes element k fetchable at edge t+1 (no same-cycle bypass).
  - If the read vl exceeds the write vl, elements ≥ write vl read old contents once the write completes.
- Write-after-read: not checked. Ordering is issue logic's responsibility.
- Simultaneous starts:
  - Write and read to the same register in the same cycle: the read chains on the new write.
  - Multiple read ports on the same register: independent, no conflict.
- Output hold: rd_data_o/rd_last_o stay stable while valid && !ready.
- Reset mid-stream: all streams abort immediately; partially written register keeps the elements already written.

Decomposition:
- Package vec_rf_pkg holds the default parameter constants and the FSM state encoding (IDLE=1'b0, ACTIVE=1'b1).
- Sub-module vec_rf_read_port, instantiated NUM_READ_PORTS times by generate. It contains the read FSM, rd_cnt, output register, hazard compare, and a combinational element mux from the storage array.
- Top level holds storage, the write FSM, and the write counter/register broadcast to read ports.

Test Plan:
- Write v3, vl=8, data 0x10..0x17 with valid held → wr_ready_o high 8 cycles, wr_busy_o drops after 8th. Then read port0 v3 vl=8, ready=1 → rd_data 0x10..0x17 on consecutive cycles starting 2 cycles after start, rd_last_o with 0x17.
- Backpressure: port1 reads v3 vl=4, rd_ready_i toggled 1,0,0,1,... → each element held stable while ready=0, sequence 0x10..0x13 with no loss or duplication.
- Chaining: start write v5 vl=8 with valid every other cycle; same cycle start read port0 v5 vl=8 → each rd element k appears only after write k, data matches, no stale value emitted.
- Clamp and ignore: write start vl=0 → wr_busy_o stays 0. Read start vl=12 with VLEN_ELEMS=8 → exactly 8 elements, last asserted on 8th. Second rd_start_i while busy → ignored.
- Dual port: port0 reads v3 and port1 reads v7 (pre-filled 0x70..0x77) concurrently → both streams correct, full rate.
- Reset mid-stream: assert rst_i after 3 written elements of v9 → all outputs 0 immediately. After reset, reading v9 returns the 3 written elements for indices 0..2.
